mop_accum_ctrl: RTL



---
 rtl/mop_accum_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mop_accum_ctrl.sv
// mop_accum_ctrl: sequential m-operand adder controller.
// Accumulates groups of up to M unsigned operands, one per cycle, through a
// single shared ripple-carry adder. Each group's exact sum is presented on a
// registered valid/ready result port.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   in_valid   - operand present
//   in_ready   - controller can accept an operand
//   in_data    - unsigned operand, WIDTH bits
//   in_last    - operand closes its group
//   out_valid  - group sum available
//   out_ready  - consumer accepts the sum
//   out_sum    - group sum, SW bits (WIDTH + guard bits)
//   out_count  - operands in the group, 1..M
//   busy       - partial group held or result pending

// Ripple-carry adder: a_i + b_i + cin_i.
module cpa #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);
    // Each stage keeps its own carry so the chain is a plain net list.
    for (genvar i = 0; i < W; i++) begin : g_bit
        logic c_in_b;
        logic c_out_b;
        if (i == 0) begin : g_first
            assign c_in_b = cin_i;
        end else begin : g_next
            assign c_in_b = g_bit[i-1].c_out_b;
        end
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c_in_b;
        assign c_out_b  = (a_i[i] & b_i[i]) | (c_in_b & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = g_bit[W-1].c_out_b;
endmodule

module mop_accum_ctrl #(
    parameter  int unsigned WIDTH = 64,
    parameter  int unsigned M     = 8,
    localparam int unsigned SW    = WIDTH + $clog2(M),
    localparam int unsigned CW    = $clog2(M + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SW-1:0]    out_sum,
    output logic [CW-1:0]    out_count,
    output logic             busy
);
    typedef enum logic {
        S_ACC  = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   out_sum_q, out_sum_d;
    logic [CW-1:0]   out_count_q, out_count_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    logic [SW-1:0]   cpa_a;
    logic [SW-1:0]   cpa_b;
    logic [SW-1:0]   cpa_sum;
    logic            cpa_cout;
    logic [CW-1:0]   count_inc;
    logic            accept;

    // Shared adder operands: a fresh group starts from zero.
    assign cpa_a     = (count_q != '0) ? acc_q : '0;
    assign cpa_b     = SW'(in_data);
    assign count_inc = CW'(count_q + CW'(1));
    assign accept    = in_valid && in_ready_q;

    cpa #(.W(SW)) u_cpa (
        .a_i    (cpa_a),
        .b_i    (cpa_b),
        .cin_i  (1'b0),
        .sum_o  (cpa_sum),
        .cout_o (cpa_cout)
    );

    // Guard bits make a carry out of the accumulator impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        accept |-> !cpa_cout);

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;

        unique case (state_q)
            S_ACC: begin
                if (accept) begin
                    acc_d   = cpa_sum;
                    count_d = count_inc;
                    // The M-th operand closes the group even without in_last.
                    if (in_last || (count_inc == CW'(M))) begin
                        out_sum_d   = cpa_sum;
                        out_count_d = count_inc;
                        state_d     = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_ACC;
                    count_d = '0;
                    acc_d   = '0;
                end
            end
            default: state_d = S_ACC;
        endcase

        in_ready_d  = (state_d == S_ACC);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d == S_DONE) || (count_d != '0);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_ACC;
            acc_q       <= '0;
            count_q     <= '0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign busy      = busy_q;
endmodule
